// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with registered result, flags and a start/busy/done handshake.
// Define SEQ_ALU_DIV_EN to build the restoring divider (op 10); otherwise op 10 is illegal.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       sreg
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                         OP_MUL = 4'd8, OP_CMP = 4'd9, OP_DIV = 4'd10;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL_RUN} state_t;
`endif

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic [3:0]       sreg_q;

  logic [WIDTH-1:0] a_q, acc_hi_q, acc_lo_q;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   div_sh, div_trial;
`endif

  function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                            input logic z, input logic c);
    return {v, n, z, c};
  endfunction

  logic [WIDTH:0]   sum_w, diff_w;
  logic             v_add, v_sub, c_d, v_d, upd_d;
  logic [WIDTH-1:0] flag_src, sc_res_d, sc_hi_d;
  logic [3:0]       sc_sreg_d;

  // Single-cycle ops: evaluated on the live inputs, captured on the accepting edge.
  always_comb begin
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    v_add     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    v_sub     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
    sc_res_d  = '0;
    sc_hi_d   = '0;
    sc_sreg_d = sreg_q;
    flag_src  = '0;
    c_d       = 1'b0;
    v_d       = 1'b0;
    upd_d     = 1'b1;
    case (op)
      OP_ADD: begin sc_res_d = sum_w[WIDTH-1:0];  c_d = sum_w[WIDTH];  v_d = v_add; end
      OP_SUB: begin sc_res_d = diff_w[WIDTH-1:0]; c_d = diff_w[WIDTH]; v_d = v_sub; end
      OP_AND: sc_res_d = a & b;
      OP_OR:  sc_res_d = a | b;
      OP_XOR: sc_res_d = a ^ b;
      OP_NOT: sc_res_d = ~a;
      OP_SHL: begin sc_res_d = {a[WIDTH-2:0], 1'b0}; c_d = a[WIDTH-1]; end
      OP_SHR: begin sc_res_d = {1'b0, a[WIDTH-1:1]}; c_d = a[0]; end
      OP_CMP: begin
        sc_res_d = result_q;
        sc_hi_d  = result_hi_q;
        c_d      = diff_w[WIDTH];
        v_d      = v_sub;
      end
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        sc_res_d  = '1;
        sc_hi_d   = a;
        sc_sreg_d = pack_flags(1'b1, 1'b1, 1'b0, 1'b0);
        upd_d     = 1'b0;
      end
`endif
      default: upd_d = 1'b0;
    endcase
    flag_src = (op == OP_CMP) ? diff_w[WIDTH-1:0] : sc_res_d;
    if (upd_d) sc_sreg_d = pack_flags(v_d, flag_src[WIDTH-1], ~|flag_src, c_d);
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] it_hi_d, it_lo_d;
  logic [3:0]       run_sreg_d;

  // One iteration step: MUL shifts {carry,hi,lo} right; DIV shifts {rem,quot} left and trial-subtracts.
  always_comb begin
    mul_sum    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : {WIDTH{1'b0}})};
    it_hi_d    = mul_sum[WIDTH:1];
    it_lo_d    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    run_sreg_d = pack_flags(1'b0, it_hi_d[WIDTH-1], ~|{it_hi_d, it_lo_d}, |it_hi_d);
`ifdef SEQ_ALU_DIV_EN
    div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, b_q};
    if (state_q == DIV_RUN) begin
      if (!div_trial[WIDTH]) begin
        it_hi_d = div_trial[WIDTH-1:0];
        it_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        it_hi_d = div_sh[WIDTH-1:0];
        it_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
      run_sreg_d = pack_flags(1'b0, it_lo_d[WIDTH-1], ~|it_lo_d, 1'b0);
    end
`endif
  end

  // Operand/accumulator datapath carries no reset; the FSM decides when it is meaningful.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (start) begin
        a_q      <= a;
        acc_hi_q <= '0;
        acc_lo_q <= (op == OP_DIV) ? a : b;
`ifdef SEQ_ALU_DIV_EN
        b_q      <= b;
`endif
      end
    end else begin
      acc_hi_q <= it_hi_d;
      acc_lo_q <= it_lo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      sreg_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              state_q <= MUL_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
            end
`ifdef SEQ_ALU_DIV_EN
            else if (op == OP_DIV && b != '0) begin
              state_q <= DIV_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
            end
`endif
            else begin
              result_q    <= sc_res_d;
              result_hi_q <= sc_hi_d;
              sreg_q      <= sc_sreg_d;
              done_q      <= 1'b1;
            end
          end
        end
        default: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= it_lo_d;
            result_hi_q <= it_hi_d;
            sreg_q      <= run_sreg_d;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign sreg      = sreg_q;

endmodule
